// File: rtl/keyboard_controls.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_controls
// Description : Player-input controller. Tracks held state of four game keys
//               from PS/2 make/brake events, resolves left/right into a single
//               movement command (last pressed wins), toggles pause and issues
//               cooldown-spaced fire pulses.
//               Optional feature macro: KBD_AUTOFIRE_EN (fire repeats while the
//               fire key is held).
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_controls #(
  parameter logic [8:0] KEY_LEFT      = 9'h16B,
  parameter logic [8:0] KEY_RIGHT     = 9'h174,
  parameter logic [8:0] KEY_FIRE      = 9'h029,
  parameter logic [8:0] KEY_PAUSE     = 9'h04D,
  parameter int         FIRE_COOLDOWN = 25_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brake,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       paused,
  output logic       fire_ready
);

  localparam int                 CNT_W    = $clog2(FIRE_COOLDOWN);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FIRE_COOLDOWN - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {D_NONE = 2'd0, D_LEFT = 2'd1, D_RIGHT = 2'd2} dir_t;
  typedef enum logic [0:0] {F_READY = 1'b0, F_COOL = 1'b1} fire_st_t;

  dir_t             dir_q, dir_d;
  fire_st_t         fst_q, fst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_left_q, held_left_d;
  logic             held_right_q, held_right_d;
  logic             held_fire_q, held_fire_d;
  logic             held_pause_q, held_pause_d;
  logic             paused_q, paused_d;
  logic             move_left_q, move_left_d;
  logic             move_right_q, move_right_d;
  logic             fire_q, fire_d;
  logic             fire_ready_q, fire_ready_d;

  logic             press, release_ev;
  logic             hit_left, hit_right, hit_fire, hit_pause;
  logic             left_press, right_press, fire_press, pause_press;
  logic             left_rel, right_rel;
  logic             fire_trig;

  // Event decode, held tracking, direction/pause/fire next-state logic
  always_comb begin
    // A strobe pair in the same cycle is ambiguous and therefore discarded
    press      = make & ~brake;
    release_ev = brake & ~make;

    hit_left  = (keyCode == KEY_LEFT);
    hit_right = (keyCode == KEY_RIGHT);
    hit_fire  = (keyCode == KEY_FIRE);
    hit_pause = (keyCode == KEY_PAUSE);

    // Press edges exclude typematic repeats of an already-held key
    left_press  = press & hit_left  & ~held_left_q;
    right_press = press & hit_right & ~held_right_q;
    fire_press  = press & hit_fire  & ~held_fire_q;
    pause_press = press & hit_pause & ~held_pause_q;
    left_rel    = release_ev & hit_left;
    right_rel   = release_ev & hit_right;

    held_left_d  = (held_left_q  | (press & hit_left))  & ~(release_ev & hit_left);
    held_right_d = (held_right_q | (press & hit_right)) & ~(release_ev & hit_right);
    held_fire_d  = (held_fire_q  | (press & hit_fire))  & ~(release_ev & hit_fire);
    held_pause_d = (held_pause_q | (press & hit_pause)) & ~(release_ev & hit_pause);

    dir_d = dir_q;
    if (left_press) begin
      dir_d = D_LEFT;
    end else if (right_press) begin
      dir_d = D_RIGHT;
    end else if (left_rel && dir_q == D_LEFT) begin
      dir_d = held_right_q ? D_RIGHT : D_NONE;
    end else if (right_rel && dir_q == D_RIGHT) begin
      dir_d = held_left_q ? D_LEFT : D_NONE;
    end

    paused_d = paused_q ^ pause_press;

`ifdef KBD_AUTOFIRE_EN
    fire_trig = fire_press | held_fire_q;
`else
    fire_trig = fire_press;
`endif

    fire_d = 1'b0;
    fst_d  = fst_q;
    cnt_d  = cnt_q;
    case (fst_q)
      F_READY: begin
        if (fire_trig && !paused_q) begin
          fire_d = 1'b1;
          fst_d  = F_COOL;
          cnt_d  = CNT_LOAD;
        end
      end
      default: begin
        // Counter saturates at zero; READY is entered as it reaches zero
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          fst_d = F_READY;
        end
      end
    endcase

    move_left_d  = (dir_d == D_LEFT)  & ~paused_d;
    move_right_d = (dir_d == D_RIGHT) & ~paused_d;
    // One-cycle lag keeps fire_ready high during the pulse cycle itself
    fire_ready_d = (fst_q == F_READY);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_q        <= D_NONE;
      fst_q        <= F_READY;
      cnt_q        <= '0;
      held_left_q  <= 1'b0;
      held_right_q <= 1'b0;
      held_fire_q  <= 1'b0;
      held_pause_q <= 1'b0;
      paused_q     <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      fire_ready_q <= 1'b1;
    end else begin
      dir_q        <= dir_d;
      fst_q        <= fst_d;
      cnt_q        <= cnt_d;
      held_left_q  <= held_left_d;
      held_right_q <= held_right_d;
      held_fire_q  <= held_fire_d;
      held_pause_q <= held_pause_d;
      paused_q     <= paused_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      fire_q       <= fire_d;
      fire_ready_q <= fire_ready_d;
    end
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fire       = fire_q;
  assign paused     = paused_q;
  assign fire_ready = fire_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_controls.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyboard_controls
// Description : Directed self-checking bench for keyboard_controls
//               (FIRE_COOLDOWN = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_controls;

  logic       clk = 1'b0;
  logic       resetN;
  logic [8:0] keyCode;
  logic       make, brake;
  logic       move_left, move_right, fire, paused, fire_ready;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  int base;

  keyboard_controls #(.FIRE_COOLDOWN(8)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .keyCode    (keyCode),
    .make       (make),
    .brake      (brake),
    .move_left  (move_left),
    .move_right (move_right),
    .fire       (fire),
    .paused     (paused),
    .fire_ready (fire_ready)
  );

  always #5 clk = ~clk;

  // Count fire pulses, sampled away from the active edge
  always @(negedge clk) if (fire === 1'b1) fire_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [8:0] code, input logic mk, input logic bk);
    keyCode = code;
    make    = mk;
    brake   = bk;
    tick();
    make    = 1'b0;
    brake   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mv(input string tag, input logic l, input logic r);
    chk({tag, "_left"}, move_left, l);
    chk({tag, "_right"}, move_right, r);
  endtask

  initial begin
    resetN = 1'b0; keyCode = '0; make = 1'b0; brake = 1'b0;
    tick(); tick();
    chk_mv("rst", 1'b0, 1'b0);
    chk("rst_fire", fire, 1'b0);
    chk("rst_paused", paused, 1'b0);
    chk("rst_ready", fire_ready, 1'b1);
    resetN = 1'b1;
    tick();

    // Left/right override, last pressed wins
    ev(9'h16B, 1, 0); chk_mv("ovr_l", 1, 0);
    ev(9'h174, 1, 0); chk_mv("ovr_r", 0, 1);
    ev(9'h174, 0, 1); chk_mv("ovr_rel_r", 1, 0);
    ev(9'h16B, 0, 1); chk_mv("ovr_rel_l", 0, 0);
    // Releasing the inactive key does not move the direction
    ev(9'h16B, 1, 0); ev(9'h174, 1, 0);
    ev(9'h16B, 0, 1); chk_mv("inact_rel", 0, 1);
    ev(9'h174, 0, 1); chk_mv("inact_rel2", 0, 0);

    // Typematic repeats toggle pause only once
    ev(9'h04D, 1, 0); chk("rep1", paused, 1);
    ev(9'h04D, 1, 0); chk("rep2", paused, 1);
    ev(9'h04D, 1, 0); chk("rep3", paused, 1);
    ev(9'h04D, 0, 1); chk("rep_rel", paused, 1);
    ev(9'h04D, 1, 0); chk("rep_unp", paused, 0);
    ev(9'h04D, 0, 1); chk("rep_unp_rel", paused, 0);

    // Simultaneous strobes and unknown code are ignored
    ev(9'h16B, 1, 1); chk_mv("both", 0, 0);
    // If left had been registered held, right release would revert to left
    ev(9'h174, 1, 0); ev(9'h174, 0, 1); chk_mv("both_noheld", 0, 0);
    ev(9'h01C, 1, 0);
    chk_mv("unk", 0, 0);
    chk("unk_paused", paused, 0);
    chk("unk_fire", fire, 0);

    // Fire cooldown: strobe cycle 10, pulse at 11, ready low 12..18
    base = fire_cnt;
    ev(9'h029, 1, 0);                      // now cycle 11
    chk("cool_fire", fire, 1);
    chk("cool_ready11", fire_ready, 1);
    ev(9'h029, 0, 1);                      // cycle 12
    chk("cool_fire_w", fire, 0);
    chk("cool_ready12", fire_ready, 0);
    tick(); tick();                        // cycle 14
    ev(9'h029, 1, 0);                      // cycle 15
    chk("cool_drop", fire, 0);
    ev(9'h029, 0, 1);                      // cycle 16
    chk("cool_ready16", fire_ready, 0);
    tick(); tick();                        // cycle 18
    chk("cool_ready18", fire_ready, 0);
    tick();                                // cycle 19
    chk("cool_ready19", fire_ready, 1);
    chk_int("cool_pulses", fire_cnt - base, 1);
    ev(9'h029, 1, 0);
    chk("refire", fire, 1);
    ev(9'h029, 0, 1);
    chk("refire_single", fire, 0);
    repeat (10) tick();

    // Pause gating of movement and fire
    ev(9'h16B, 1, 0); chk_mv("pg_hold", 1, 0);
    ev(9'h04D, 1, 0); chk_mv("pg_paused", 0, 0);
    chk("pg_paused_flag", paused, 1);
    ev(9'h04D, 0, 1);
    base = fire_cnt;
    ev(9'h029, 1, 0); chk("pg_nofire", fire, 0);
    ev(9'h029, 0, 1);
    tick();
    chk_int("pg_pulses", fire_cnt - base, 0);
    chk("pg_ready", fire_ready, 1);
    ev(9'h04D, 1, 0); chk_mv("pg_resume", 1, 0);
    chk("pg_unpaused", paused, 0);
    ev(9'h04D, 0, 1);
    ev(9'h16B, 0, 1); chk_mv("pg_rel", 0, 0);

    // Hold fire for 40 cycles
    base = fire_cnt;
    ev(9'h029, 1, 0);                      // strobe cycle C, now C+1
    chk("af_first", fire, 1);
    repeat (7) tick();                     // C+8
    chk("af_gap", fire, 0);
    tick();                                // C+9
`ifdef KBD_AUTOFIRE_EN
    chk("af_second", fire, 1);
`else
    chk("af_second", fire, 0);
`endif
    repeat (30) tick();                    // C+39
    ev(9'h029, 0, 1);
    repeat (12) tick();
`ifdef KBD_AUTOFIRE_EN
    chk_int("af_pulses", fire_cnt - base, 5);
`else
    chk_int("af_pulses", fire_cnt - base, 1);
`endif

    // Reset mid-cooldown clears immediately
    ev(9'h029, 1, 0);
    chk("rmc_fire", fire, 1);
    tick(); tick();
    chk("rmc_cool", fire_ready, 0);
    #2 resetN = 1'b0;
    #1;
    chk("rmc_ready", fire_ready, 1);
    chk("rmc_fire0", fire, 0);
    tick();
    resetN = 1'b1;
    base = fire_cnt;
    repeat (10) tick();
    chk_int("rmc_nopend", fire_cnt - base, 0);
    chk("rmc_ready2", fire_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_controls.md
# keyboard_controls

Player-input controller between the PS/2 keyboard interface and the game logic. It consumes decoded make/brake events and tracks the held state of four game keys. It resolves left/right into one movement command (last pressed wins) and schedules fire pulses through a cooldown counter. A pause toggle gates movement and fire.

## Interface
Parameters:
- KEY_LEFT, 9'h16B, left arrow (extended code, bit 8 = E0 prefix)
- KEY_RIGHT, 9'h174, right arrow
- KEY_FIRE, 9'h029, space bar
- KEY_PAUSE, 9'h04D, P key
- FIRE_COOLDOWN, 25_000_000, minimum clk cycles between fire pulses (≥2)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- keyCode  in  9  scan code of current event; bit 8 set for E0-prefixed keys
- make  in  1  one-cycle strobe: keyCode was pressed
- brake  in  1  one-cycle strobe: keyCode was released
- move_left  out  1  level: move left
- move_right  out  1  level: move right
- fire  out  1  one-cycle fire pulse
- paused  out  1  level: game paused
- fire_ready  out  1  level: cooldown expired

## Operation
- **Event qualification.**
  - An event is valid when exactly one of make/brake is high.
  - If both are high in the same cycle, the event is ignored.
  - A keyCode that matches no parameter is ignored.
- **Held tracking.**
  - One held bit per key.
  - make sets the bit; brake clears it.
  - A make on an already-held key is a typematic repeat. It changes no state and triggers no edge action.
- **Direction FSM (states D_NONE, D_LEFT, D_RIGHT).**
  - A left press edge goes to D_LEFT. A right press edge goes to D_RIGHT.
  - Releasing the active key goes to the other direction if that key is still held, otherwise to D_NONE.
  - Releasing the inactive key causes no transition.
  - move_left = (state==D_LEFT) & ~paused.
  - move_right = (state==D_RIGHT) & ~paused.
  - The two move outputs are never high together.
- **Pause.**
  - The press edge of KEY_PAUSE toggles paused. Release has no effect.
  - Held tracking and the direction FSM keep running while paused.
  - Unpausing with a key still held resumes movement immediately.
- **Fire FSM (states F_READY, F_COOL).**
  - In F_READY, a fire press edge with paused=0 emits fire. It then loads the cooldown counter with FIRE_COOLDOWN-1 and goes to F_COOL.
  - In F_COOL, the counter decrements once per cycle. At 0 the FSM goes to F_READY.
  - A fire press edge during F_COOL or while paused is dropped, not queued.
  - fire_ready = (state==F_READY).
- **Counter width.** The counter is $clog2(FIRE_COOLDOWN) bits and never wraps: it holds at 0 once reached.

## Timing
- **Reset values.**
  - All outputs reset to 0, except fire_ready = 1.
  - Direction resets to D_NONE, fire to F_READY, all held bits to 0, counter to 0.
- **Latency.**
  - All outputs are registered.
  - A strobe in cycle N is reflected on move_*, paused and fire in cycle N+1.
  - fire is high for exactly one cycle.
- **Fire spacing.** Consecutive fire pulses are at least FIRE_COOLDOWN cycles apart, measured rising edge to rising edge.
  - Fire at N: F_COOL from N+1, fire_ready = 0 in cycles N+1 … N+FIRE_COOLDOWN-1.
  - F_READY again, fire_ready = 1, at cycle N+FIRE_COOLDOWN.
- **Fire edge on the expiry cycle.** A fire press edge arriving in the cycle the counter reaches 0 is dropped.
- **Reset mid-cooldown.** Asserting resetN low mid-cooldown clears everything immediately, with no pending fire.

## Configuration
- **KBD_AUTOFIRE_EN defined.**
  - In F_READY, if the fire key is held and paused=0, fire is emitted with no new press edge required.
  - Holding space therefore yields one pulse every FIRE_COOLDOWN cycles.
- **KBD_AUTOFIRE_EN undefined.**
  - Fire is emitted only on a press edge.
  - Holding the key yields exactly one pulse; a release and re-press is needed for the next.

## Test plan
(FIRE_COOLDOWN=8 for all scenarios.)
1. **Left/right override.**
   - Stimulus: make 16B, make 174, brake 174, brake 16B.
   - Response: move_left=1, then move_right=1/move_left=0, then move_left=1, then both 0; never both high.
2. **Typematic repeat filtering.**
   - Stimulus: make 04D three times without brake.
   - Response: paused toggles once, to 1.
   - Stimulus: brake 04D, then make 04D.
   - Response: paused=0.
3. **Fire cooldown.**
   - Stimulus: make 029 at cycle 10, brake, make 029 at cycle 14.
   - Response: one fire pulse at 11; second make dropped; fire_ready=0 in cycles 12–18 and 1 at 19.
4. **Pause gating.**
   - Stimulus: hold 16B, toggle pause on.
   - Response: move_left=0, make 029 produces no fire.
   - Stimulus: toggle pause off.
   - Response: move_left=1 the next cycle.
5. **Simultaneous strobes / unknown code.**
   - Stimulus: make=brake=1 with 16B; then make with 9'h01C.
   - Response: no output change.
6. **Autofire macro.**
   - Stimulus: hold 029 for 40 cycles.
   - Response with KBD_AUTOFIRE_EN: 5 pulses, 8 cycles apart. Without it: 1 pulse.
   - Reset mid-cooldown: fire_ready=1 immediately.
